// File: rtl/input_pkg.sv
// -----------------------------------------------------------------------------
// input_pkg
// Shared definitions for the front-panel input conditioner: default debounce
// length and switch-bank width, the debounce counter width helper, and the
// channel layout used when the raw inputs are packed into one vector.
// -----------------------------------------------------------------------------
package input_pkg;

   // 10 ms at the 5 MHz oscillator clock.
   localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
   localparam int NUM_SWITCHES_DEFAULT    = 8;

   // Control channels that precede the general switch bank in the packed
   // channel vector.
   localparam int CH_STEP              = 0;
   localparam int CH_CPU_RESET         = 1;
   localparam int CH_INSTR_N_CYCLE     = 2;
   localparam int CH_STEP_N_RUN        = 3;
   localparam int CH_ENABLE_BREAKPOINT = 4;
   localparam int NUM_CTRL_CHANNELS    = 5;

   // Counter holds 0 .. cycles-1, so ceil(log2(cycles)) bits suffice.
   function automatic int counterWidth(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One-bit conditioner: 2-flop synchronizer followed by a saturating debounce
// counter and a stable-level register.
//
// Ports
//   clk      in   conditioner clock, rising edge
//   reset    in   synchronous, active-high; clears synchronizer, count, level
//   rawIn    in   raw asynchronous input bit
//   syncOut  out  second synchronizer flop (raw input delayed by 2 edges)
//   level    out  debounced level, driven straight from the stable register
// -----------------------------------------------------------------------------
module debounce_channel
   import input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic rawIn,
   output logic syncOut,
   output logic level
);

   localparam int CW = counterWidth(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] count;
   logic          stable;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         count  <= '0;
         stable <= 1'b0;
      end else begin
         sync1 <= rawIn;
         sync2 <= sync1;
         // Any agreement restarts the run; only an unbroken run of
         // DEBOUNCE_CYCLES disagreeing samples moves the stable level.
         if (sync2 == stable) begin
            count <= '0;
         end else if (count == LAST_COUNT) begin
            stable <= sync2;
            count  <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

   assign syncOut = sync2;
   assign level   = stable;

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Synchronizes and debounces the front-panel buttons and switches, turns the
// step button into a single-cycle pulse per press and flags any change of the
// data switch bank with a single-cycle pulse.
//
// Ports
//   i_oszClk              in   single clock, rising edge
//   i_reset               in   synchronous, active-high reset
//   i_btnStep             in   raw step button (1 = pressed)
//   i_btnReset            in   raw CPU-reset button (1 = pressed)
//   i_swInstrNCycle       in   raw mode switch
//   i_swStepNRun          in   raw mode switch
//   i_swEnableBreakpoint  in   raw mode switch
//   i_switches            in   raw data switches [NUM_SWITCHES]
//   o_stepPulse           out  one-cycle pulse per accepted step press
//   o_cpuReset            out  debounced CPU-reset button level
//   o_swInstrNCycle       out  debounced mode switch
//   o_swStepNRun          out  debounced mode switch
//   o_swEnableBreakpoint  out  debounced mode switch
//   o_switches            out  debounced data switches [NUM_SWITCHES]
//   o_switchesChanged     out  one-cycle pulse after any o_switches change
// -----------------------------------------------------------------------------
module input_conditioner
   import input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int NUM_SWITCHES    = NUM_SWITCHES_DEFAULT
) (
   input  logic                    i_oszClk,
   input  logic                    i_reset,
   input  logic                    i_btnStep,
   input  logic                    i_btnReset,
   input  logic                    i_swInstrNCycle,
   input  logic                    i_swStepNRun,
   input  logic                    i_swEnableBreakpoint,
   input  logic [NUM_SWITCHES-1:0] i_switches,
   output logic                    o_stepPulse,
   output logic                    o_cpuReset,
   output logic                    o_swInstrNCycle,
   output logic                    o_swStepNRun,
   output logic                    o_swEnableBreakpoint,
   output logic [NUM_SWITCHES-1:0] o_switches,
   output logic                    o_switchesChanged
);

   localparam int NUM_CHANNELS = NUM_CTRL_CHANNELS + NUM_SWITCHES;

   logic [NUM_CHANNELS-1:0] rawVec;
   logic [NUM_CHANNELS-1:0] syncVec;
   logic [NUM_CHANNELS-1:0] stableVec;
   logic [NUM_SWITCHES-1:0] switchesStable;
   logic                    syncUnused;

   logic                    stepStable;
   logic                    stepSync;
   logic [1:0]              syncFilled;
   logic                    stepArmed;
   logic                    stepPrev;
   logic                    stepPulseReg;
   logic [NUM_SWITCHES-1:0] switchesPrev;
   logic                    switchesChangedReg;

   // Channel order matches the CH_* indices in input_pkg.
   assign rawVec = {i_switches, i_swEnableBreakpoint, i_swStepNRun,
                    i_swInstrNCycle, i_btnReset, i_btnStep};

   for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : genChannel
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) uChannel (
         .clk    (i_oszClk),
         .reset  (i_reset),
         .rawIn  (rawVec[ch]),
         .syncOut(syncVec[ch]),
         .level  (stableVec[ch])
      );
   end

   // Only the step channel's synchronizer output feeds the arm logic.
   assign syncUnused = ^syncVec[NUM_CHANNELS-1:1];

   assign stepStable     = stableVec[CH_STEP];
   assign stepSync       = syncVec[CH_STEP];
   assign switchesStable = stableVec[NUM_CHANNELS-1:NUM_CTRL_CHANNELS];

   always_ff @(posedge i_oszClk) begin
      if (i_reset) begin
         syncFilled         <= 2'b00;
         stepArmed          <= 1'b0;
         stepPrev           <= 1'b0;
         stepPulseReg       <= 1'b0;
         switchesPrev       <= '0;
         switchesChangedReg <= 1'b0;
      end else begin
         // The stable register reads 0 right after reset even when the button
         // is held, so arming also requires the synchronizer to have refilled
         // with real samples and to show the button released.
         syncFilled <= {syncFilled[0], 1'b1};
         if (syncFilled[1] && !stepStable && !stepSync) begin
            stepArmed <= 1'b1;
         end
         stepPrev           <= stepStable;
         stepPulseReg       <= stepArmed && stepStable && !stepPrev;
         switchesPrev       <= switchesStable;
         switchesChangedReg <= |(switchesStable ^ switchesPrev);
      end
   end

   assign o_stepPulse          = stepPulseReg;
   assign o_cpuReset           = stableVec[CH_CPU_RESET];
   assign o_swInstrNCycle      = stableVec[CH_INSTR_N_CYCLE];
   assign o_swStepNRun         = stableVec[CH_STEP_N_RUN];
   assign o_swEnableBreakpoint = stableVec[CH_ENABLE_BREAKPOINT];
   assign o_switches           = switchesStable;
   assign o_switchesChanged    = switchesChangedReg;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4 and eight
// data switches: a vector table, directed multi-cycle sequences and a random
// phase, all cross-checked every cycle against a history-based model.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

   localparam int D    = 4;
   localparam int NSW  = 8;
   localparam int NCH  = NSW + 5;
   localparam int MAXE = 8192;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic           btnStep;
   logic           btnReset;
   logic           swInstr;
   logic           swStepRun;
   logic           swBrk;
   logic [NSW-1:0] sw;

   logic           stepPulse;
   logic           cpuReset;
   logic           oInstr;
   logic           oStepRun;
   logic           oBrk;
   logic [NSW-1:0] oSw;
   logic           swChanged;

   input_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .NUM_SWITCHES   (NSW)
   ) dut (
      .i_oszClk            (clk),
      .i_reset             (rst),
      .i_btnStep           (btnStep),
      .i_btnReset          (btnReset),
      .i_swInstrNCycle     (swInstr),
      .i_swStepNRun        (swStepRun),
      .i_swEnableBreakpoint(swBrk),
      .i_switches          (sw),
      .o_stepPulse         (stepPulse),
      .o_cpuReset          (cpuReset),
      .o_swInstrNCycle     (oInstr),
      .o_swStepNRun        (oStepRun),
      .o_swEnableBreakpoint(oBrk),
      .o_switches          (oSw),
      .o_switchesChanged   (swChanged)
   );

   int checks   = 0;
   int failures = 0;

   // ---------------------------------------------------------------------
   // Reference model: per-edge history of raw samples and reset. A channel's
   // level flips at edge k when the D most recent synchronized samples
   // (raw delayed two edges, zero while the synchronizer refills after a
   // reset) all disagree with the current level and no reset fell inside
   // that window.
   // ---------------------------------------------------------------------
   logic [NCH-1:0] rawH   [MAXE];
   logic           rstH   [MAXE];
   logic [NCH-1:0] stH    [MAXE];
   logic           armH   [MAXE];
   logic           pulseH [MAXE];
   logic           chgH   [MAXE];
   int             edgeN = -1;

   function automatic logic isRst(input int k);
      return (k < 0) ? 1'b1 : rstH[k];
   endfunction

   function automatic logic syncSeen(input int k, input int ch);
      if (k < 2 || isRst(k - 1) || isRst(k - 2)) return 1'b0;
      return rawH[k - 2][ch];
   endfunction

   int             mk;
   logic [NCH-1:0] mPrev;
   logic [NCH-1:0] mPrev2;
   logic [NCH-1:0] mNext;
   logic           mFlip;
   logic           mArmPrev;

   always @(posedge clk) begin
      mk = edgeN + 1;
      if (mk < MAXE) begin
         rawH[mk] = {sw, swBrk, swStepRun, swInstr, btnReset, btnStep};
         rstH[mk] = rst;
         if (rst) begin
            stH[mk]    = '0;
            armH[mk]   = 1'b0;
            pulseH[mk] = 1'b0;
            chgH[mk]   = 1'b0;
         end else begin
            mPrev    = (mk >= 1) ? stH[mk - 1] : '0;
            mPrev2   = (mk >= 2) ? stH[mk - 2] : '0;
            mArmPrev = (mk >= 1) ? armH[mk - 1] : 1'b0;
            mNext    = mPrev;
            for (int ch = 0; ch < NCH; ch++) begin
               mFlip = 1'b1;
               for (int m = 0; m < D; m++) begin
                  if (isRst(mk - m) || syncSeen(mk - m, ch) == mPrev[ch]) mFlip = 1'b0;
               end
               if (mFlip) mNext[ch] = ~mPrev[ch];
            end
            stH[mk]    = mNext;
            // Armed once a genuinely released button has been seen since reset.
            armH[mk]   = mArmPrev || (!isRst(mk - 1) && !isRst(mk - 2) &&
                                      !mPrev[0] && !syncSeen(mk, 0));
            // Pulse in the cycle after the step level rose, if armed by then.
            pulseH[mk] = mArmPrev && mPrev[0] && !mPrev2[0];
            chgH[mk]   = !isRst(mk - 1) && (mPrev[NCH-1:5] != mPrev2[NCH-1:5]);
         end
         edgeN = mk;
      end
   end

   logic [NCH+0:0] expVec;
   logic [NCH+0:0] actVec;

   always @(negedge clk) begin
      if (edgeN >= 0 && edgeN < MAXE) begin
         expVec = {chgH[edgeN], stH[edgeN][NCH-1:1], pulseH[edgeN]};
         actVec = {swChanged, oSw, oBrk, oStepRun, oInstr, cpuReset, stepPulse};
         checks++;
         if (actVec !== expVec) begin
            failures++;
            $display("FAIL model edge=%0d got=%h want=%h", edgeN, actVec, expVec);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Directed helpers
   // ---------------------------------------------------------------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are read at the next one.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic           rst;
      logic           step;
      logic [NSW-1:0] sw;
      logic           expPulse;
      logic [NSW-1:0] expSw;
      logic           expChg;
   } vec_t;

   vec_t           tbl [17];
   int             pulseCnt;
   logic [NCH-1:0] rnd;
   logic           bounce [5];

   initial begin
      rst       = 1'b1;
      btnStep   = 1'b0;
      btnReset  = 1'b0;
      swInstr   = 1'b0;
      swStepRun = 1'b0;
      swBrk     = 1'b0;
      sw        = '0;

      // Switch bank 00 -> A5 -> 00, plus a 3-cycle step glitch.
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'hA5, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'hA5, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'hA5, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};

      for (int i = 0; i < 17; i++) begin
         rst     = tbl[i].rst;
         btnStep = tbl[i].step;
         sw      = tbl[i].sw;
         cyc();
         chk($sformatf("tbl%0d pulse", i), 32'(stepPulse), 32'(tbl[i].expPulse));
         chk($sformatf("tbl%0d switches", i), 32'(oSw), 32'(tbl[i].expSw));
         chk($sformatf("tbl%0d changed", i), 32'(swChanged), 32'(tbl[i].expChg));
      end

      // Press after a clean reset: one pulse, 7 edges after the raw edge.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      repeat (8) cyc();
      btnStep = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         chk($sformatf("stepPress k=%0d", k), 32'(stepPulse), 32'(k == 7));
      end
      btnStep = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         chk($sformatf("stepRelease k=%0d", k), 32'(stepPulse), 32'(0));
      end

      // Button held through reset: silent until released and pressed again.
      btnStep = 1'b1;
      repeat (10) cyc();
      rst = 1'b1;
      cyc();
      cyc();
      chk("resetState", 32'({swChanged, oSw, oBrk, oStepRun, oInstr, cpuReset, stepPulse}), 32'(0));
      rst = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         chk($sformatf("heldThroughReset k=%0d", k), 32'(stepPulse), 32'(0));
      end
      btnStep = 1'b0;
      repeat (10) cyc();
      btnStep  = 1'b1;
      pulseCnt = 0;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         if (stepPulse) pulseCnt++;
         chk($sformatf("pressAfterRelease k=%0d", k), 32'(stepPulse), 32'(k == 7));
      end
      chk("pressAfterRelease count", 32'(pulseCnt), 32'(1));
      btnStep = 1'b0;

      // Bouncing CPU-reset button: level rises 6 edges after steady 1 begins.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      bounce[0] = 1'b1; bounce[1] = 1'b0; bounce[2] = 1'b1; bounce[3] = 1'b0; bounce[4] = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         btnReset = (k <= 5) ? bounce[k - 1] : 1'b1;
         cyc();
         chk($sformatf("cpuResetBounce k=%0d", k), 32'(cpuReset), 32'(k >= 10));
      end
      btnReset = 1'b0;
      repeat (8) cyc();

      // Reset mid-debounce discards the partial count.
      rst = 1'b1;
      cyc();
      rst       = 1'b0;
      swStepRun = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         cyc();
         chk($sformatf("stepRunBefore k=%0d", k), 32'(oStepRun), 32'(0));
      end
      rst = 1'b1;
      cyc();
      chk("stepRunInReset", 32'(oStepRun), 32'(0));
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         chk($sformatf("stepRunAfterReset k=%0d", k), 32'(oStepRun), 32'(k >= 6));
      end

      // Random phase: sparse toggles (runs and glitches) with rare resets,
      // checked every cycle by the model.
      for (int i = 0; i < 2500; i++) begin
         rnd = {sw, swBrk, swStepRun, swInstr, btnReset, btnStep};
         for (int ch = 0; ch < NCH; ch++) begin
            if ($urandom_range(0, 11) == 0) rnd[ch] = ~rnd[ch];
         end
         {sw, swBrk, swStepRun, swInstr, btnReset, btnStep} = rnd;
         rst = ($urandom_range(0, 79) == 0);
         cyc();
      end

      rst = 1'b0;
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
